// File: rtl/ahb2_sram_slv.sv
// AHB2 slave terminating into a single-port SRAM with one-cycle read latency.
// Define AHB2_SRAM_SLV_ERR_EN to answer illegal transfers with ERROR.
module ahb2_sram_slv #(
  parameter int ADDR_WIDTH  = 12,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                  hclk,
  input  logic                  hreset_n,
  input  logic                  hsel,
  input  logic [31:0]           haddr,
  input  logic [1:0]            htrans,
  input  logic                  hwrite,
  input  logic [2:0]            hsize,
  input  logic [2:0]            hburst,
  input  logic [3:0]            hprot,
  input  logic [31:0]           hwdata,
  input  logic                  hreadyi,
  output logic [31:0]           hrdata,
  output logic                  hreadyo,
  output logic [1:0]            hresp,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-3:0] mem_addr,
  output logic [3:0]            mem_be,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_RD,
    S_RDW,
    S_ERR1,
    S_ERR2
  } state_t;

  state_t                r_state;
  logic [2:0]            r_cnt;
  logic [ADDR_WIDTH-3:0] r_addr;
  logic [3:0]            r_be;
  logic [31:0]           r_rdata;
  logic                  r_first;

  logic   w_acc;
  logic   w_ill;
  logic   w_rdy;
  logic   w_cnt0;
  logic   w_unused;
  logic [3:0] w_be;
  state_t w_nxt;

  assign w_acc  = hsel & hreadyi & htrans[1];
  assign w_cnt0 = (r_cnt == 3'd0);

  // Sizes above word fall to the default and act as words.
  always_comb begin
    w_be = 4'b1111;
    unique case (1'b1)
      (hsize == 3'd0): w_be = 4'b0001 << haddr[1:0];
      (hsize == 3'd1): w_be = 4'b0011 << {haddr[1], 1'b0};
      default:         w_be = 4'b1111;
    endcase
  end

`ifdef AHB2_SRAM_SLV_ERR_EN
  assign w_ill = (hsize > 3'd2)
               | ((hsize == 3'd1) & haddr[0])
               | ((hsize == 3'd2) & (|haddr[1:0]))
               | (|haddr[31:ADDR_WIDTH]);
`else
  assign w_ill = 1'b0;
`endif

  assign w_unused = ^{hburst, hprot, haddr[31:ADDR_WIDTH]};

  always_comb begin
    w_nxt = S_IDLE;
    if (w_acc) begin
      if (w_ill)       w_nxt = S_ERR1;
      else if (hwrite) w_nxt = S_WR;
      else             w_nxt = S_RD;
    end
  end

  // Final data-phase cycle (or idle): the next address phase may be taken.
  assign w_rdy = (r_state == S_IDLE)
               | (r_state == S_ERR2)
               | ((r_state == S_WR)  & w_cnt0)
               | ((r_state == S_RDW) & w_cnt0);

  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 3'd0;
      r_addr  <= '0;
      r_be    <= 4'b0000;
      r_rdata <= 32'd0;
      r_first <= 1'b0;
    end else begin
      r_first <= (r_state == S_RD);
      if (r_first) r_rdata <= mem_rdata;
      if (w_rdy) begin
        r_state <= w_nxt;
        if (w_acc) begin
          r_cnt  <= 3'(WAIT_CYCLES);
          r_addr <= haddr[ADDR_WIDTH-1:2];
          r_be   <= w_be;
        end
      end else begin
        unique case (r_state)
          S_RD:    r_state <= S_RDW;
          S_ERR1:  r_state <= S_ERR2;
          default: r_cnt   <= r_cnt - 3'd1;
        endcase
      end
    end
  end

  // SRAM data arrives in the first RDW cycle; forward it if that is final.
  assign hrdata  = (r_first & w_cnt0) ? mem_rdata : r_rdata;
  assign hreadyo = w_rdy;

`ifdef AHB2_SRAM_SLV_ERR_EN
  assign hresp = {1'b0, (r_state == S_ERR1) | (r_state == S_ERR2)};
`else
  assign hresp = 2'b00;
`endif

  assign mem_req   = (r_state == S_RD) | ((r_state == S_WR) & w_cnt0);
  assign mem_we    = (r_state == S_WR) & w_cnt0;
  assign mem_addr  = r_addr;
  assign mem_be    = r_be;
  assign mem_wdata = hwdata;

endmodule

// File: tb/tb_ahb2_sram_slv.sv
// Bench for ahb2_sram_slv: three instances (0, 3 and 2 wait states)
// driven by a pipelined AHB driver with a scoreboard queue.
module tb_ahb2_sram_slv;

  localparam int NI = 3;

  typedef struct {
    bit          sel;
    logic [1:0]  trans;
    bit          wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic [9:0]  maddr;
    logic [3:0]  be;
    logic [31:0] rdata;
    bit          err;
  } vec_t;

  logic        hclk;
  logic        hreset_n;
  logic        hsel      [NI];
  logic [31:0] haddr     [NI];
  logic [1:0]  htrans    [NI];
  logic        hwrite    [NI];
  logic [2:0]  hsize     [NI];
  logic [2:0]  hburst    [NI];
  logic [3:0]  hprot     [NI];
  logic [31:0] hwdata    [NI];
  logic [31:0] hrdata    [NI];
  logic        hreadyo   [NI];
  logic [1:0]  hresp     [NI];
  logic        mem_req   [NI];
  logic        mem_we    [NI];
  logic [9:0]  mem_addr  [NI];
  logic [3:0]  mem_be    [NI];
  logic [31:0] mem_wdata [NI];
  logic [31:0] mem_rdata [NI];

  logic [31:0] sram [NI][1024];

  int   n_cmp;
  int   n_bad;
  vec_t stim_q [$];
  vec_t sb_q   [$];
  vec_t tbl    [$];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    ahb2_sram_slv #(
      .ADDR_WIDTH (12),
      .WAIT_CYCLES((g == 0) ? 0 : ((g == 1) ? 3 : 2))
    ) u_dut (
      .hclk     (hclk),
      .hreset_n (hreset_n),
      .hsel     (hsel[g]),
      .haddr    (haddr[g]),
      .htrans   (htrans[g]),
      .hwrite   (hwrite[g]),
      .hsize    (hsize[g]),
      .hburst   (hburst[g]),
      .hprot    (hprot[g]),
      .hwdata   (hwdata[g]),
      .hreadyi  (hreadyo[g]),
      .hrdata   (hrdata[g]),
      .hreadyo  (hreadyo[g]),
      .hresp    (hresp[g]),
      .mem_req  (mem_req[g]),
      .mem_we   (mem_we[g]),
      .mem_addr (mem_addr[g]),
      .mem_be   (mem_be[g]),
      .mem_wdata(mem_wdata[g]),
      .mem_rdata(mem_rdata[g])
    );
  end

  initial begin
    hclk = 1'b0;
    forever #5 hclk = ~hclk;
  end

  // Behavioural SRAM behind each instance.
  always @(posedge hclk) begin
    for (int i = 0; i < NI; i++) begin
      if (mem_req[i]) begin
        if (mem_we[i]) begin
          for (int b = 0; b < 4; b++)
            if (mem_be[i][b])
              sram[i][mem_addr[i]][8*b +: 8] <= mem_wdata[i][8*b +: 8];
        end else begin
          mem_rdata[i] <= sram[i][mem_addr[i]];
        end
      end
    end
  end

  function automatic int wc(input int k);
    return (k == 0) ? 0 : ((k == 1) ? 3 : 2);
  endfunction

  function automatic vec_t mk(
    input bit sel, input logic [1:0] tr, input bit wr,
    input logic [31:0] a, input logic [2:0] sz,
    input logic [31:0] wd, input logic [9:0] ma,
    input logic [3:0] be, input logic [31:0] rd,
    input bit err);
    vec_t v;
    v.sel = sel; v.trans = tr; v.wr = wr; v.addr = a;
    v.size = sz; v.wdata = wd; v.maddr = ma; v.be = be;
    v.rdata = rd; v.err = err;
    return v;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive_next(input int k, output bit nv,
                            output vec_t nx);
    if (stim_q.size() != 0) begin
      nx        = stim_q.pop_front();
      hsel[k]   = nx.sel;
      haddr[k]  = nx.addr;
      htrans[k] = nx.trans;
      hwrite[k] = nx.wr;
      hsize[k]  = nx.size;
      nv        = 1'b1;
    end else begin
      nx        = mk(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
      hsel[k]   = 1'b0;
      htrans[k] = 2'b00;
      nv        = 1'b0;
    end
  endtask

  task automatic complete(input int k, input int waits,
                          input int mreq);
    vec_t e;
    int   ew;
    e  = sb_q.pop_front();
    ew = e.err ? 1 : (e.wr ? wc(k) : wc(k) + 1);
    chk("waits", waits, ew);
    chk("resp", {30'd0, hresp[k]}, e.err ? 1 : 0);
    chk("mem_req_cnt", mreq, e.err ? 0 : 1);
    if (!e.err) begin
      chk("mem_addr", {22'd0, mem_addr[k]}, {22'd0, e.maddr});
      chk("mem_be", {28'd0, mem_be[k]}, {28'd0, e.be});
      if (e.wr) begin
        chk("mem_we", {31'd0, mem_we[k]}, 1);
        chk("mem_wdata", mem_wdata[k], e.wdata);
      end else begin
        chk("hrdata", hrdata[k], e.rdata);
      end
    end
  endtask

  // Pipelined driver: next address phase overlaps the final data cycle.
  task automatic run(input int k, output int span);
    vec_t nx;
    bit   cv, nv, acc, ichk, done, started;
    int   waits, mreq;
    cv = 0; nv = 0; ichk = 0; done = 0; started = 0;
    span = 0; waits = 0; mreq = 0;
    @(posedge hclk); #1;
    drive_next(k, nv, nx);
    for (int c = 0; c < 300 && !done; c++) begin
      @(negedge hclk);
      acc = hreadyo[k];
      if (ichk) begin
        chk("idle_rdy", {31'd0, hreadyo[k]}, 1);
        chk("idle_resp", {30'd0, hresp[k]}, 0);
        chk("idle_req", {31'd0, mem_req[k]}, 0);
        ichk = 0;
      end
      if (started) span++;
      if (cv) begin
        if (mem_req[k]) mreq++;
        if (!hreadyo[k]) begin
          waits++;
          chk("wait_resp", {30'd0, hresp[k]},
              sb_q[0].err ? 1 : 0);
        end else begin
          complete(k, waits, mreq);
          cv = 0;
        end
      end
      if (!cv && !nv) begin
        done = 1;
      end else begin
        @(posedge hclk); #1;
        if (acc) begin
          if (nv && nx.sel && nx.trans[1]) begin
            sb_q.push_back(nx);
            cv = 1; waits = 0; mreq = 0; started = 1;
            hwdata[k] = nx.wdata;
          end else if (nv) begin
            ichk = 1;
          end
          drive_next(k, nv, nx);
        end
      end
    end
    if (!done) chk("run_timeout", 0, 1);
  endtask

  task automatic addr_phase(input int k, input bit wr,
                            input logic [31:0] a);
    hsel[k]   = 1'b1;
    haddr[k]  = a;
    htrans[k] = 2'b10;
    hwrite[k] = wr;
    hsize[k]  = 3'd2;
  endtask

  task automatic bus_idle(input int k);
    hsel[k]   = 1'b0;
    htrans[k] = 2'b00;
  endtask

  initial begin
    int span;
    int nreq;
    n_cmp = 0;
    n_bad = 0;
    hreset_n = 1'b0;
    for (int k = 0; k < NI; k++) begin
      hsel[k] = 0; haddr[k] = 0; htrans[k] = 0; hwrite[k] = 0;
      hsize[k] = 0; hburst[k] = 0; hprot[k] = 0; hwdata[k] = 0;
    end

    repeat (3) @(negedge hclk);
    for (int k = 0; k < NI; k++) begin
      chk("rst_rdy", {31'd0, hreadyo[k]}, 1);
      chk("rst_resp", {30'd0, hresp[k]}, 0);
      chk("rst_hrdata", hrdata[k], 0);
      chk("rst_req", {31'd0, mem_req[k]}, 0);
      chk("rst_we", {31'd0, mem_we[k]}, 0);
      chk("rst_addr", {22'd0, mem_addr[k]}, 0);
      chk("rst_be", {28'd0, mem_be[k]}, 0);
    end
    hreset_n = 1'b1;

    tbl.push_back(mk(1,2'b10,1,32'h004,2,32'hDEADBEEF,1,4'b1111,0,0));
    tbl.push_back(mk(1,2'b10,0,32'h006,0,0,1,4'b0100,32'hDEADBEEF,0));
    tbl.push_back(mk(1,2'b10,1,32'h008,2,32'h0,2,4'b1111,0,0));
    tbl.push_back(mk(1,2'b10,1,32'h00A,1,32'h12345678,2,4'b1100,0,0));
    tbl.push_back(mk(1,2'b10,0,32'h008,2,0,2,4'b1111,32'h12340000,0));
    tbl.push_back(mk(1,2'b10,1,32'h000,2,32'h01020304,0,4'b1111,0,0));
    tbl.push_back(mk(1,2'b10,1,32'h003,0,32'hAABBCCDD,0,4'b1000,0,0));
    tbl.push_back(mk(1,2'b10,0,32'h002,1,0,0,4'b1100,32'hAA020304,0));
    tbl.push_back(mk(1,2'b00,0,32'h004,2,0,0,0,0,0));
    tbl.push_back(mk(1,2'b01,0,32'h004,2,0,0,0,0,0));
    tbl.push_back(mk(0,2'b10,1,32'h004,2,32'h0,0,0,0,0));
    tbl.push_back(mk(1,2'b11,0,32'h004,2,0,1,4'b1111,32'hDEADBEEF,0));
`ifdef AHB2_SRAM_SLV_ERR_EN
    tbl.push_back(mk(1,2'b10,0,32'h002,2,0,0,0,0,1));
    tbl.push_back(mk(1,2'b10,0,32'h1000,2,0,0,0,0,1));
    tbl.push_back(mk(1,2'b10,1,32'h008,3,32'h55667788,0,0,0,1));
    tbl.push_back(mk(1,2'b10,0,32'h008,2,0,2,4'b1111,32'h12340000,0));
`else
    tbl.push_back(mk(1,2'b10,0,32'h002,2,0,0,4'b1111,32'hAA020304,0));
    tbl.push_back(mk(1,2'b10,0,32'h1000,2,0,0,4'b1111,32'hAA020304,0));
    tbl.push_back(mk(1,2'b10,1,32'h008,3,32'h55667788,2,4'b1111,0,0));
    tbl.push_back(mk(1,2'b10,0,32'h008,2,0,2,4'b1111,32'h55667788,0));
`endif
    for (int i = 0; i < tbl.size(); i++) stim_q.push_back(tbl[i]);
    run(0, span);

    // Back-to-back write then read with three wait states.
    stim_q.push_back(mk(1,2'b10,1,32'h010,2,32'hCAFEF00D,4,4'b1111,0,0));
    stim_q.push_back(mk(1,2'b10,0,32'h010,2,0,4,4'b1111,32'hCAFEF00D,0));
    run(1, span);
    chk("b2b_span", span, 9);

    // Prime instance 2 so hrdata holds a nonzero value.
    stim_q.push_back(mk(1,2'b10,1,32'h000,2,32'h0BADF00D,0,4'b1111,0,0));
    stim_q.push_back(mk(1,2'b10,0,32'h000,2,0,0,4'b1111,32'h0BADF00D,0));
    run(2, span);
    chk("prime_hrdata", hrdata[2], 32'h0BADF00D);

    // Reset while waiting in RDW.
    @(posedge hclk); #1;
    addr_phase(2, 1'b0, 32'h000);
    @(posedge hclk); #1;
    bus_idle(2);
    chk("rd_req", {31'd0, mem_req[2]}, 1);
    @(posedge hclk); #1;
    chk("rdw_wait", {31'd0, hreadyo[2]}, 0);
    hreset_n = 1'b0;
    #1;
    chk("arst_rdy", {31'd0, hreadyo[2]}, 1);
    chk("arst_hrdata", hrdata[2], 0);
    chk("arst_req", {31'd0, mem_req[2]}, 0);
    chk("arst_resp", {30'd0, hresp[2]}, 0);
    @(negedge hclk);
    hreset_n = 1'b1;
    nreq = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge hclk);
      if (mem_req[2] || !hreadyo[2]) nreq++;
    end
    chk("arst_quiet", nreq, 0);

    // Reset during write wait states: the write must not land.
    @(posedge hclk); #1;
    addr_phase(2, 1'b1, 32'h000);
    hwdata[2] = 32'h11111111;
    @(posedge hclk); #1;
    bus_idle(2);
    #1 hreset_n = 1'b0;
    #2 hreset_n = 1'b1;
    stim_q.push_back(mk(1,2'b10,0,32'h000,2,0,0,4'b1111,32'h0BADF00D,0));
    run(2, span);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
